pdm_demod: RTL and testbench
============================

Name: pdm_demod

Overview:
- Pulse-density demodulator: recovers an NBITS-wide sample from a 1-bit PDM stream by counting ones over a fixed window of 2^DECIM_LOG2 samples (boxcar decimation).
- Receive-side counterpart of the team's first-order PDM modulator.
- Used for loopback checks of PDM DAC outputs and to read PDM sensors/ADCs, including sources on an external pin (hence the optional input synchronizer).

Parameters:
- NBITS, 11, output sample width.
- DECIM_LOG2, 11, log2 of window length in ce-qualified samples; range 1..16.
- SYNC_STAGES, 2, flip-flops on din before counting; 0 means din is used directly.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  sample enable; din is counted only in cycles where the synchronized ce is high.
- din  input  1  PDM bit stream.
- dout  output  NBITS  demodulated sample, held between updates.
- valid  output  1  one-cycle pulse when dout updates.
- sat  output  1  one-cycle pulse, coincident with valid, when the window count was clipped.

Behaviour:
- Synchronizer: din passes through SYNC_STAGES registers (reset to 0). ce is delayed by the same number of stages so sample alignment is preserved.
- Counting state:
  - sample_cnt: DECIM_LOG2 bits.
  - ones_cnt: DECIM_LOG2+1 bits, so it can hold 2^DECIM_LOG2.
- Each cycle with delayed ce=1:
  - sample_cnt increments, wrapping to 0.
  - ones_cnt accumulates the delayed din bit.
- Window end: the ce cycle where sample_cnt = 2^DECIM_LOG2-1.
  - total = ones_cnt + din_d.
  - ones_cnt is cleared to 0 on the next edge; no sample is lost across window boundaries.
  - On the same edge, dout is loaded with scale(total) and valid/sat are set for exactly one cycle.
- scale():
  - DECIM_LOG2 = NBITS: total unchanged.
  - DECIM_LOG2 < NBITS: total shifted left by NBITS-DECIM_LOG2.
  - DECIM_LOG2 > NBITS: total shifted right by DECIM_LOG2-NBITS (truncation).
  - If the result exceeds 2^NBITS-1, dout = 2^NBITS-1 and sat = 1. This includes the all-ones window, where total = 2^DECIM_LOG2.
- Latency: valid rises 1 + SYNC_STAGES clk cycles after the clk edge that presents the last window bit on din (input pins).
- ce low: the counters hold and no valid is produced. ce may be low for arbitrarily long stretches mid-window.
- Reset values: dout = 0, valid = 0, sat = 0, sample_cnt = 0, ones_cnt = 0, sync registers = 0.
- Reset mid-window discards the partial window. The first window after release starts with the first qualified sample.
- Window alignment is relative to reset release only; there is no external frame input.
- Round trip with the team's modulator at equal NBITS and DECIM_LOG2: for constant input x, every full window after settling yields dout = x exactly. This holds because the first-order modulator emits exactly x ones per 2^NBITS consecutive samples after its first period.

Test Plan:
- NBITS=11, DECIM_LOG2=11, SYNC_STAGES=2, ce=1, din=0 constant -> valid every 2048 cycles, dout=0, sat=0; first valid at cycle 2048+1+2 after reset release.
- Same config, din=1 constant -> dout=2047, sat=1 with every valid.
- Modulator(NBITS=11) driving din with x=1024, then 5, then 2047 -> second and later windows give dout=1024, 5, 2047 exactly, sat=0 (2047 count is 2047, not clipped).
- ce toggling 1-in-4 cycles, din=1 only on ce cycles for 100 samples per window, else 0 -> valid every 8192 cycles, dout=100; din activity on ce=0 cycles is ignored.
- DECIM_LOG2=4, NBITS=8, din pattern of 5 ones per 16 samples -> dout=80 (5<<4). DECIM_LOG2=12, NBITS=8, 2048 ones -> dout=128.
- rst asserted for 1 cycle at sample 1000 of a window -> no valid for that window; dout, valid and sat are 0 the cycle after reset; the next valid arrives 2048 qualified samples after release with a correct count.

Source files
------------

// File: rtl/pdm_demod_if.sv
// PDM demodulator bus: qualified 1-bit stream in, decimated samples out.
// master drives ce/din and reads dout/valid/sat; slave is the demodulator.
interface pdm_demod_if #(
  parameter int NBITS = 11
);
  logic             ce;
  logic             din;
  logic [NBITS-1:0] dout;
  logic             valid;
  logic             sat;

  modport master (
    output ce, din,
    input  dout, valid, sat
  );

  modport slave (
    input  ce, din,
    output dout, valid, sat
  );
endinterface

// File: rtl/pdm_demod.sv
// Boxcar PDM demodulator: counts ones over 2^DECIM_LOG2 ce samples.
// Ports: clk, rst (sync, active high), bus (slave: ce/din in, dout/valid/sat out).
module pdm_demod #(
  parameter int NBITS       = 11,
  parameter int DECIM_LOG2  = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  pdm_demod_if.slave bus
);

  localparam int CW  = DECIM_LOG2 + 1;
  localparam int SW  = NBITS + DECIM_LOG2 + 1;
  localparam int LSH = (NBITS > DECIM_LOG2) ? NBITS - DECIM_LOG2 : 0;
  localparam int RSH = (DECIM_LOG2 > NBITS) ? DECIM_LOG2 - NBITS : 0;

  localparam logic [DECIM_LOG2-1:0] LAST = '1;
  localparam logic [SW-1:0] MAXV =
    {{(SW-NBITS){1'b0}}, {NBITS{1'b1}}};

  logic ce_d;
  logic din_d;

  // ce travels with din so each bit keeps its qualifier
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign ce_d  = bus.ce;
      assign din_d = bus.din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] ce_sr;
      logic [SYNC_STAGES-1:0] din_sr;

      always_ff @(posedge clk) begin
        if (rst) begin
          ce_sr  <= '0;
          din_sr <= '0;
        end else begin
          ce_sr  <= (ce_sr << 1) | SYNC_STAGES'(bus.ce);
          din_sr <= (din_sr << 1) | SYNC_STAGES'(bus.din);
        end
      end

      assign ce_d  = ce_sr[SYNC_STAGES-1];
      assign din_d = din_sr[SYNC_STAGES-1];
    end
  endgenerate

  logic [DECIM_LOG2-1:0] sample_cnt;
  logic [CW-1:0]         ones_cnt;
  logic [CW-1:0]         total;
  logic [SW-1:0]         scaled;
  logic                  last;
  logic                  clip;

  always_comb begin
    last   = ce_d && (sample_cnt == LAST);
    total  = ones_cnt + CW'(din_d);
    scaled = (SW'(total) << LSH) >> RSH;
    clip   = scaled > MAXV;
  end

  // window end reloads ones_cnt with 0 so the next bit
  // starts a fresh window without a gap
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
      ones_cnt   <= '0;
      bus.dout   <= '0;
      bus.valid  <= 1'b0;
      bus.sat    <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      bus.sat   <= 1'b0;
      if (ce_d) begin
        sample_cnt <= sample_cnt + DECIM_LOG2'(1);
        ones_cnt   <= last ? '0 : total;
      end
      if (last) begin
        bus.valid <= 1'b1;
        bus.sat   <= clip;
        bus.dout  <= clip ? '1 : scaled[NBITS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pdm_demod.sv
// Scoreboard bench for pdm_demod over three window/width configurations.
// Shared stimulus; each instance has its own window model and monitor.
module tb_pdm_demod;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  logic din = 1'b0;
  logic rst_q = 1'b1;
  bit   done = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_chk = 0;

  typedef struct {
    int dout;
    bit sat;
    int cyc;
  } exp_t;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  function automatic void check(string name, int act, int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d",
                  name, act, req, cyc);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int N = (g == 0) ? 11 : 8;
    localparam int D = (g == 0) ? 11 : ((g == 1) ? 4 : 12);
    localparam int S = (g == 0) ? 2 : ((g == 1) ? 0 : 1);

    pdm_demod_if #(.NBITS(N)) bus ();

    assign bus.ce  = ce;
    assign bus.din = din;

    pdm_demod #(
      .NBITS(N),
      .DECIM_LOG2(D),
      .SYNC_STAGES(S)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    exp_t q[$];

    // reference: collect qualified pin bits into windows,
    // value = ones * 2^N / 2^D, clipped to N bits
    initial begin
      int cnt;
      int ones;
      longint v;
      longint maxv;
      cnt  = 0;
      ones = 0;
      maxv = (longint'(1) << N) - 1;
      forever begin
        @(posedge clk);
        if (rst) begin
          cnt  = 0;
          ones = 0;
        end else if (ce) begin
          cnt++;
          ones += int'(din);
          if (cnt == (1 << D)) begin
            v = (longint'(ones) << N) >> D;
            q.push_back('{dout: (v > maxv) ? int'(maxv) : int'(v),
                          sat:  (v > maxv),
                          cyc:  cyc + S + 1});
            cnt  = 0;
            ones = 0;
          end
        end
      end
    end

    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        if (rst_q) begin
          check($sformatf("rst_dout%0d", g), int'(bus.dout), 0);
          check($sformatf("rst_valid%0d", g), int'(bus.valid), 0);
          check($sformatf("rst_sat%0d", g), int'(bus.sat), 0);
        end else if (bus.valid) begin
          if (q.size() == 0) begin
            check($sformatf("spurious_valid%0d", g), 1, 0);
          end else begin
            e = q.pop_front();
            check($sformatf("dout%0d", g), int'(bus.dout), e.dout);
            check($sformatf("sat%0d", g), int'(bus.sat), int'(e.sat));
            check($sformatf("latency%0d", g), cyc, e.cyc);
          end
        end
      end
    end

    initial begin
      wait (done);
      check($sformatf("pending%0d", g), q.size(), 0);
    end
  end

  task automatic step(input bit c, input bit d);
    @(negedge clk);
    ce  = c;
    din = d;
  endtask

  initial begin
    logic [11:0] acc;
    int xs[3];
    xs  = '{1024, 5, 2047};
    acc = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    repeat (2048) step(1'b1, 1'b0);
    repeat (2048) step(1'b1, 1'b1);

    // first-order modulator feeding constant levels
    for (int k = 0; k < 3; k++) begin
      repeat (3 * 2048) begin
        acc = {1'b0, acc[10:0]} + 12'(xs[k]);
        step(1'b1, acc[11]);
      end
    end

    // 1-in-4 ce, 100 ones per window, noise on idle cycles
    for (int i = 0; i < 8192; i++) begin
      if (i % 4 == 0) step(1'b1, (i / 4) < 100);
      else step(1'b0, ($urandom % 2) == 1);
    end

    // reset partway into a window
    repeat (1000) step(1'b1, ($urandom % 2) == 1);
    repeat (4) step(1'b0, ($urandom % 2) == 1);
    @(negedge clk);
    rst = 1'b1;
    ce  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2048) step(1'b1, ($urandom % 2) == 1);

    repeat (4096) step(($urandom % 3) != 0, ($urandom % 2) == 1);

    repeat (10) step(1'b0, 1'b0);
    done = 1'b1;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
